bcd_onehot_scanner: RTL and testbench
=====================================

# bcd_onehot_scanner

Digit-serial, parametrised BCD-to-decimal decoder. Accepts a packed word of DIGITS BCD codes over a valid/ready handshake. Decodes one digit per clock, most-significant first, into a 10-bit one-hot field per digit, with optional leading-zero blanking and per-digit invalid-code flags. Sits between the BCD counter/arithmetic datapath and the display drivers, and replaces per-digit combinational decode with one shared decoder.

## Interface
- DIGITS, 4: number of BCD digits per word (≥1).
- BLANK_LZ, 1: 1 = leading zeros blank their field to all-zero; 0 = every zero decodes to bit 0.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_bcd  in  4*DIGITS  digit k = in_bcd[4k+3:4k]; k=0 least significant.
- out_valid  out  1  decoded word valid.
- out_ready  in  1  consumer accepts the word.
- out_onehot  out  10*DIGITS  field k = out_onehot[10k+9:10k]; code n (0–9) sets bit n only.
- out_err_mask  out  DIGITS  bit k set if digit k code > 9.
- out_err  out  1  OR of out_err_mask.

## Operation
- FSM: IDLE, SCAN, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid: capture in_bcd, set idx=DIGITS-1, set lz=1, clear out_onehot and out_err_mask, go to SCAN.
- SCAN: each cycle decode digit idx into field idx.
  - Code 0–9: one-hot. If code ≠ 0, clear lz.
  - Code 10–15: field=0, err_mask[idx]=1, clear lz.
  - BLANK_LZ=1, lz=1, code=0, idx≠0: field=0 and lz stays 1. Digit 0 is never blanked.
  - idx==0: register out_err, go to HOLD; otherwise decrement idx.
- HOLD:
  - out_valid=1. Outputs stay stable until out_ready.
  - On out_ready: if in_valid is also high, capture the new word (same rules as IDLE) and go to SCAN; otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). It is forced 0 while rst_n is low.
- in_bcd is sampled only on the accept edge. Later input changes have no effect.

## Timing
- Reset values: state IDLE, out_valid 0, out_onehot 0, out_err_mask 0, out_err 0, idx 0, lz 0.
- Asserting rst_n at any point, including mid-SCAN or HOLD, aborts the word. There is no partial output.
- Latency: accept edge at cycle 0 → out_valid high after edge DIGITS.
- Throughput: one word per DIGITS+1 cycles with back-to-back handshakes. out_valid drops for exactly DIGITS cycles between words.
- out_onehot, out_err_mask and out_err are registered. They are valid only while out_valid=1 and do not change while out_valid=1 & !out_ready.
- DIGITS=1: SCAN lasts 1 cycle. Blanking never applies.

## Structure
- Package bcd_pkg holds:
  - BCD_W=4 and DEC_W=10.
  - state enum {IDLE, SCAN, HOLD}.
  - localparam for idx width: $clog2(DIGITS), minimum 1.
- Sub-module bcd_digit_onehot: combinational 4-bit code → 10-bit one-hot plus invalid flag. It is instantiated once and shared across digits.
- The top level holds the FSM, capture register, idx counter, lz flag and output registers.

## Test plan
- DIGITS=4, BLANK_LZ=1, in_bcd=16'h1209 → after 4 cycles out_onehot={10'h002,10'h004,10'h001,10'h200}, out_err=0.
- in_bcd=16'h0007, BLANK_LZ=1 → {0,0,0,10'h080}. Same word with BLANK_LZ=0 → {10'h001,10'h001,10'h001,10'h080}. in_bcd=16'h0000, BLANK_LZ=1 → {0,0,0,10'h001}.
- in_bcd=16'h3A5F → out_onehot={10'h008,0,10'h020,0}, out_err_mask=4'b0101, out_err=1.
- Backpressure and overlap:
  - HOLD with out_ready=0 for 5 cycles → outputs bit-stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 → new word accepted on that edge, out_valid=0 next cycle and 1 again 4 cycles later.
- rst_n pulsed low during SCAN (idx=2) → all outputs 0 immediately. After release, the block is in IDLE with in_ready=1, and the next word decodes correctly with no residue.
- Random words, DIGITS in {1,3,4}, random in_valid/out_ready → every accepted word matches the reference model, in order, with no loss or duplication.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD to one-hot scanner.
// Included by the top level and the per-digit decoder.
package bcd_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned DEC_W = 10;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StHold
    } state_e;

    // Width of the digit index counter; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/bcd_digit_onehot.sv
// Combinational decode of one 4-bit BCD code into a 10-bit one-hot field.
// Codes above nine produce an all-zero field and raise err_o.
module bcd_digit_onehot
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] code_i,
    output logic [DEC_W-1:0] onehot_o,
    output logic             err_o
);

    always_comb begin
        onehot_o = '0;
        err_o    = 1'b0;
        if (code_i <= BCD_W'(9)) begin
            onehot_o = DEC_W'(1) << code_i;
        end else begin
            err_o = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_onehot_scanner.sv
// Digit-serial BCD decoder: captures a word of DIGITS codes, decodes one digit per
// clock (most significant first) through a single shared decoder, then holds the result.
module bcd_onehot_scanner
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BCD_W*DIGITS-1:0] in_bcd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DEC_W*DIGITS-1:0] out_onehot,
    output logic [DIGITS-1:0]       out_err_mask,
    output logic                    out_err
);

    localparam int unsigned IDX_W = idx_width(DIGITS);

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      lz_q, lz_d;
    logic [BCD_W*DIGITS-1:0]   bcd_q, bcd_d;
    logic [DEC_W*DIGITS-1:0]   onehot_q, onehot_d;
    logic [DIGITS-1:0]         err_mask_q, err_mask_d;
    logic                      err_q, err_d;

    logic                      ready_int;
    logic                      accept;
    logic                      blank;
    logic [BCD_W-1:0]          cur_code;
    logic [DEC_W-1:0]          cur_onehot;
    logic                      cur_err;

    assign ready_int = (state_q == StIdle) | ((state_q == StHold) & out_ready);
    assign accept    = in_valid & ready_int;

    // Select the digit currently being scanned from the capture register.
    always_comb begin
        cur_code = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_code = bcd_q[k*BCD_W +: BCD_W];
            end
        end
    end

    bcd_digit_onehot u_dec (
        .code_i   (cur_code),
        .onehot_o (cur_onehot),
        .err_o    (cur_err)
    );

    // Digit 0 always shows, so a word of all zeros still displays a single 0.
    assign blank = BLANK_LZ && lz_q && (cur_code == '0) && (idx_q != '0);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        lz_d       = lz_q;
        bcd_d      = bcd_q;
        onehot_d   = onehot_q;
        err_mask_d = err_mask_q;
        err_d      = err_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        onehot_d[k*DEC_W +: DEC_W] = blank ? '0 : cur_onehot;
                        err_mask_d[k]              = cur_err;
                    end
                end
                if (cur_code != '0) begin
                    lz_d = 1'b0;
                end
                if (idx_q == '0) begin
                    err_d   = |err_mask_d;
                    state_d = StHold;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = accept ? StScan : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            bcd_d      = in_bcd;
            idx_d      = IDX_W'(DIGITS - 1);
            lz_d       = 1'b1;
            onehot_d   = '0;
            err_mask_d = '0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            lz_q       <= 1'b0;
            bcd_q      <= '0;
            onehot_q   <= '0;
            err_mask_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            lz_q       <= lz_d;
            bcd_q      <= bcd_d;
            onehot_q   <= onehot_d;
            err_mask_q <= err_mask_d;
            err_q      <= err_d;
        end
    end

    assign in_ready     = rst_n & ready_int;
    assign out_valid    = (state_q == StHold);
    assign out_onehot   = onehot_q;
    assign out_err_mask = err_mask_q;
    assign out_err      = err_q;

endmodule

// File: tb/tb_bcd_onehot_scanner.sv
// Bench for bcd_onehot_scanner: directed decode, backpressure and reset scenarios plus
// randomized traffic on four configurations checked against a digit-rule reference model.
module tb_bcd_onehot_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_bcd = '0;

    int total = 0;
    int passed = 0;

    // Instance 0: DIGITS=4 blank, 1: DIGITS=4 no blank, 2: DIGITS=3 blank, 3: DIGITS=1 blank.
    int digs[4]   = '{4, 4, 3, 1};
    bit blanks[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    logic        ir [4];
    logic        ov [4];
    logic        er [4];
    logic [39:0] oh [4];
    logic [3:0]  em [4];

    logic [39:0] oh0, oh1;
    logic [29:0] oh2;
    logic [9:0]  oh3;
    logic [3:0]  em0, em1;
    logic [2:0]  em2;
    logic [0:0]  em3;

    always #5 clk = ~clk;

    bcd_onehot_scanner #(.DIGITS(4), .BLANK_LZ(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_bcd(in_bcd),
        .out_valid(ov[0]), .out_ready(out_ready), .out_onehot(oh0), .out_err_mask(em0),
        .out_err(er[0])
    );
    bcd_onehot_scanner #(.DIGITS(4), .BLANK_LZ(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_bcd(in_bcd),
        .out_valid(ov[1]), .out_ready(out_ready), .out_onehot(oh1), .out_err_mask(em1),
        .out_err(er[1])
    );
    bcd_onehot_scanner #(.DIGITS(3), .BLANK_LZ(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_bcd(in_bcd[11:0]),
        .out_valid(ov[2]), .out_ready(out_ready), .out_onehot(oh2), .out_err_mask(em2),
        .out_err(er[2])
    );
    bcd_onehot_scanner #(.DIGITS(1), .BLANK_LZ(1'b1)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]), .in_bcd(in_bcd[3:0]),
        .out_valid(ov[3]), .out_ready(out_ready), .out_onehot(oh3), .out_err_mask(em3),
        .out_err(er[3])
    );

    assign oh[0] = oh0;
    assign oh[1] = oh1;
    assign oh[2] = {10'b0, oh2};
    assign oh[3] = {30'b0, oh3};
    assign em[0] = em0;
    assign em[1] = em1;
    assign em[2] = {1'b0, em2};
    assign em[3] = {3'b0, em3};

    // Reference: scan digits from the top; zeros before the first non-zero (or invalid)
    // digit are blanked when enabled, except the last digit. Result = {err, mask, onehot}.
    function automatic logic [44:0] model(input logic [15:0] w, input int digits, input bit blank);
        logic [39:0] o = '0;
        logic [3:0]  m = '0;
        bit          leading = 1'b1;
        int          c;
        for (int d = digits - 1; d >= 0; d--) begin
            c = int'(w[4*d +: 4]);
            if (c > 9) begin
                m[d] = 1'b1;
                leading = 1'b0;
            end else if (!(c == 0 && leading && blank && d != 0)) begin
                o[10*d + c] = 1'b1;
                if (c != 0) leading = 1'b0;
            end
        end
        return {|m, m, o};
    endfunction

    // Present a word and wait for the DIGITS=4 blanking instance to take it.
    task automatic send_word(input logic [15:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_bcd   = w;
        #1;
        while (!ir[0] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ir[0]) begin
            $display("FAIL send_word timeout in_ready=%0b required 1", ir[0]);
            $fatal(1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_bcd   = 16'($urandom);
    endtask

    task automatic release_word();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({ir[k], ov[k], er[k], em[k], oh[k]} !== 47'b0) begin
                $display("FAIL reset_state dut%0d got=%h required 0", k,
                         {ir[k], ov[k], er[k], em[k], oh[k]});
            end else passed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({ir[k], ov[k]} !== 2'b10) begin
                $display("FAIL reset_release dut%0d ready/valid=%b required 10", k, {ir[k], ov[k]});
            end else passed++;
        end
    endtask

    task automatic test_decode();
        logic [15:0] w [4];
        logic [39:0] e0 [4];
        logic [39:0] e1 [4];
        logic [3:0]  m [4];
        w[0] = 16'h1209; e0[0] = {10'h002, 10'h004, 10'h001, 10'h200}; e1[0] = e0[0];
        w[1] = 16'h0007; e0[1] = {10'h000, 10'h000, 10'h000, 10'h080};
        e1[1] = {10'h001, 10'h001, 10'h001, 10'h080};
        w[2] = 16'h0000; e0[2] = {10'h000, 10'h000, 10'h000, 10'h001};
        e1[2] = {10'h001, 10'h001, 10'h001, 10'h001};
        w[3] = 16'h3A5F; e0[3] = {10'h008, 10'h000, 10'h020, 10'h000}; e1[3] = e0[3];
        m[0] = 4'b0000; m[1] = 4'b0000; m[2] = 4'b0000; m[3] = 4'b0101;
        for (int t = 0; t < 4; t++) begin
            send_word(w[t]);
            for (int i = 1; i <= 4; i++) begin
                @(posedge clk); #1;
                total++;
                if ({ov[0], ov[1]} !== {2{i == 4}}) begin
                    $display("FAIL latency word%0d edge%0d out_valid=%b required %b", t, i,
                             {ov[0], ov[1]}, {2{i == 4}});
                end else passed++;
            end
            total++;
            if ({er[0], em[0], oh[0]} !== {|m[t], m[t], e0[t]}) begin
                $display("FAIL decode_blank word%0d got=%h required %h", t,
                         {er[0], em[0], oh[0]}, {|m[t], m[t], e0[t]});
            end else passed++;
            total++;
            if ({er[1], em[1], oh[1]} !== {|m[t], m[t], e1[t]}) begin
                $display("FAIL decode_noblank word%0d got=%h required %h", t,
                         {er[1], em[1], oh[1]}, {|m[t], m[t], e1[t]});
            end else passed++;
            release_word();
            total++;
            if ({ov[0], ir[0]} !== 2'b01) begin
                $display("FAIL back_to_idle word%0d valid/ready=%b required 01", t, {ov[0], ir[0]});
            end else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [44:0] e_a = {1'b0, 4'b0, 10'h200, 10'h100, 10'h080, 10'h040};
        logic [44:0] e_b = {1'b0, 4'b0, 10'h000, 10'h010, 10'h020, 10'h001};
        send_word(16'h9876);
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if ({ov[0], ir[0], er[0], em[0], oh[0]} !== {2'b10, e_a}) begin
                $display("FAIL hold_stable cycle%0d got=%h required %h", i,
                         {ov[0], ir[0], er[0], em[0], oh[0]}, {2'b10, e_a});
            end else passed++;
        end
        in_valid  = 1'b1;
        in_bcd    = 16'h0450;
        out_ready = 1'b1;
        #1;
        total++;
        if (ir[0] !== 1'b1) begin
            $display("FAIL overlap_ready in_ready=%b required 1", ir[0]);
        end else passed++;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_bcd    = 16'h9999;
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (ov[0] !== 1'b0) begin
                $display("FAIL overlap_gap edge%0d out_valid=%b required 0", i, ov[0]);
            end else passed++;
            @(posedge clk); #1;
        end
        total++;
        if ({ov[0], er[0], em[0], oh[0]} !== {1'b1, e_b}) begin
            $display("FAIL overlap_word got=%h required %h", {ov[0], er[0], em[0], oh[0]},
                     {1'b1, e_b});
        end else passed++;
        release_word();
    endtask

    task automatic test_reset_mid_scan();
        logic [44:0] e = {1'b0, 4'b0, 10'h000, 10'h020, 10'h001, 10'h100};
        send_word(16'h4321);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({ir[k], ov[k], er[k], em[k], oh[k]} !== 47'b0) begin
                $display("FAIL reset_mid_scan dut%0d got=%h required 0", k,
                         {ir[k], ov[k], er[k], em[k], oh[k]});
            end else passed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if ({ir[0], ov[0]} !== 2'b10) begin
            $display("FAIL reset_mid_idle ready/valid=%b required 10", {ir[0], ov[0]});
        end else passed++;
        send_word(16'h0508);
        repeat (4) @(posedge clk);
        #1;
        total++;
        if ({ov[0], er[0], em[0], oh[0]} !== {1'b1, e}) begin
            $display("FAIL reset_residue got=%h required %h", {ov[0], er[0], em[0], oh[0]},
                     {1'b1, e});
        end else passed++;
        release_word();
    endtask

    task automatic test_random();
        logic [44:0] q0[$], q1[$], q2[$], q3[$];
        logic [44:0] e;
        int          acc [4] = '{0, 0, 0, 0};
        bit          have;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        for (int cyc = 0; cyc < 3040; cyc++) begin
            #1;
            if (cyc < 3000) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                for (int d = 0; d < 4; d++) begin
                    in_bcd[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0
                                                                   : 4'($urandom_range(1, 15));
                end
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            for (int k = 0; k < 4; k++) begin
                if (ov[k] && out_ready) begin
                    have = 1'b0;
                    e    = '0;
                    case (k)
                        0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                        1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                        2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                        default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
                    endcase
                    total++;
                    if (!have) begin
                        $display("FAIL rand_extra dut%0d got=%h required no word", k,
                                 {er[k], em[k], oh[k]});
                    end else if ({er[k], em[k], oh[k]} !== e) begin
                        $display("FAIL rand_word dut%0d got=%h required %h", k,
                                 {er[k], em[k], oh[k]}, e);
                    end else passed++;
                end
                if (in_valid && ir[k]) begin
                    e = model(in_bcd, digs[k], blanks[k]);
                    acc[k]++;
                    case (k)
                        0: q0.push_back(e);
                        1: q1.push_back(e);
                        2: q2.push_back(e);
                        default: q3.push_back(e);
                    endcase
                end
            end
            @(posedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            int left;
            case (k)
                0: left = q0.size();
                1: left = q1.size();
                2: left = q2.size();
                default: left = q3.size();
            endcase
            total++;
            if (left != 0 || acc[k] < 50) begin
                $display("FAIL rand_drain dut%0d pending=%0d accepted=%0d required 0 and >=50", k,
                         left, acc[k]);
            end else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_reset_mid_scan();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
